// File: rtl/pe_pkg.sv
// Shared codes for the PE chain sequencer: PE modes, command codes, FSM states.
package pe_pkg;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_SAVE   = 2'd1;
  localparam logic [1:0] MODE_SA     = 2'd2;
  localparam logic [1:0] MODE_INIT   = 2'd3;

  localparam logic [1:0] CMD_MAC    = 2'd0;
  localparam logic [1:0] CMD_LOAD   = 2'd1;
  localparam logic [1:0] CMD_STREAM = 2'd2;
  localparam logic [1:0] CMD_NOP    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAC,
    ST_LOAD,
    ST_STREAM,
    ST_DRAIN,
    ST_FIN
  } state_e;

  // Commands that do no PE work and go straight to FIN.
  function automatic logic cmd_short(
    input logic [1:0] c,
    input logic       len_zero
  );
    return (c == CMD_NOP) || ((c != CMD_LOAD) && len_zero);
  endfunction

endpackage

// File: rtl/pe_vld_pipe.sv
// Enabled valid shift register tracking activate through the PE chain.
module pe_vld_pipe #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (clr) begin
      sr_d = '0;
    end else if (en) begin
      sr_d    = sr_q << 1;
      sr_d[0] = d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  assign q = sr_q[DEPTH-1];

endmodule

// File: rtl/pe_seq_ctrl.sv
// Command sequencer for a daisy-chained PE array: mode/activate drive,
// operand handshake and last-PE result flagging.
module pe_seq_ctrl
  import pe_pkg::*;
#(
  parameter int N_PE  = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       cmd,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [1:0]       mode_o,
  output logic             act_o,
  output logic             out_vld,
  output logic             busy,
  output logic             done
);

  localparam int DW    = $clog2(N_PE) + 1;
  localparam int CNT_W = (LEN_W > DW) ? LEN_W : DW;
  localparam logic [CNT_W-1:0] DRAIN_LEN = CNT_W'(N_PE - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_e           state_q, state_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_dec;
  logic             tail;
  logic             pipe_en;
  logic             pipe_clr;

  assign cnt_dec = (cnt_q != '0) ? cnt_q - ONE : cnt_q;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    mode_o  = MODE_INIT;
    act_o   = 1'b0;
    in_rdy  = 1'b0;
    out_vld = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d = CNT_W'(len);
          if (cmd_short(cmd, len == '0)) begin
            cmd_d   = CMD_NOP;
            state_d = ST_FIN;
          end else begin
            cmd_d = cmd;
            unique case (cmd)
              CMD_LOAD: state_d = ST_LOAD;
              CMD_MAC:  state_d = ST_MAC;
              default:  state_d = ST_STREAM;
            endcase
          end
        end
      end
      ST_LOAD: begin
        in_rdy = 1'b1;
        if (in_vld) begin
          mode_o  = MODE_SAVE;
          state_d = ST_FIN;
        end
      end
      ST_MAC: begin
        in_rdy = 1'b1;
        if (in_vld) begin
          mode_o = MODE_SINGLE;
          cnt_d  = cnt_dec;
          if (cnt_q <= ONE) state_d = ST_FIN;
        end
      end
      ST_STREAM: begin
        in_rdy = 1'b1;
        // Stalled cycles freeze the chain, so a held tail is not a new result.
        if (in_vld) begin
          mode_o  = MODE_SA;
          act_o   = 1'b1;
          out_vld = tail;
          cnt_d   = cnt_dec;
          if (cnt_q <= ONE) begin
            cnt_d   = DRAIN_LEN;
            state_d = (N_PE == 1) ? ST_FIN : ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        mode_o  = MODE_SA;
        out_vld = tail;
        cnt_d   = cnt_dec;
        if (cnt_q <= ONE) state_d = ST_FIN;
      end
      ST_FIN: begin
        done    = 1'b1;
        out_vld = (cmd_q == CMD_MAC) | tail;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      cmd_d   = CMD_NOP;
      cnt_d   = '0;
      mode_o  = MODE_INIT;
      act_o   = 1'b0;
      in_rdy  = 1'b0;
      out_vld = 1'b0;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_NOP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign pipe_en  = (mode_o != MODE_INIT);
  assign pipe_clr = abort | (state_q == ST_FIN);

  pe_vld_pipe #(
    .DEPTH (N_PE)
  ) u_pipe (
    .clk (clk),
    .rst (rst),
    .en  (pipe_en),
    .clr (pipe_clr),
    .d   (act_o),
    .q   (tail)
  );

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed-vector bench for pe_seq_ctrl with a behavioural MAC accumulator.
module tb_pe_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] cmd;
  logic [7:0] len;
  logic       abort;
  logic       in_vld;
  logic       in_rdy;
  logic [1:0] mode_o;
  logic       act_o;
  logic       out_vld;
  logic       busy;
  logic       done;

  logic [7:0] op_a, op_b;
  int         acc = 0;
  int         n_pass = 0;
  int         n_tot = 0;

  always #5 clk = ~clk;

  pe_seq_ctrl #(
    .N_PE  (4),
    .LEN_W (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .cmd     (cmd),
    .len     (len),
    .abort   (abort),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .mode_o  (mode_o),
    .act_o   (act_o),
    .out_vld (out_vld),
    .busy    (busy),
    .done    (done)
  );

  // Single-PE accumulator: adds a*b on every MAC beat.
  always @(posedge clk)
    if (!rst && in_vld && in_rdy && mode_o == 2'd0)
      acc <= acc + int'(op_a) * int'(op_b);

  typedef struct {
    logic       st;
    logic [1:0] cmd;
    logic [7:0] len;
    logic       ab;
    logic       vld;
    logic [7:0] a;
    logic [7:0] b;
    logic [6:0] exp;
  } vec_t;

  vec_t tv[64];
  int   nv = 0;

  function automatic logic [6:0] E(int m, int ac, int r, int o, int b, int d);
    return {2'(m), 1'(ac), 1'(r), 1'(o), 1'(b), 1'(d)};
  endfunction

  task automatic add(input int st, input int c, input int l, input int ab,
                     input int vld, input int a, input int b,
                     input logic [6:0] e);
    tv[nv].st  = 1'(st);
    tv[nv].cmd = 2'(c);
    tv[nv].len = 8'(l);
    tv[nv].ab  = 1'(ab);
    tv[nv].vld = 1'(vld);
    tv[nv].a   = 8'(a);
    tv[nv].b   = 8'(b);
    tv[nv].exp = e;
    nv++;
  endtask

  function automatic logic [6:0] got();
    return {mode_o, act_o, in_rdy, out_vld, busy, done};
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    n_tot++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
  endtask

  task automatic drive(input int st, input int c, input int l, input int vld);
    start  = 1'(st);
    cmd    = 2'(c);
    len    = 8'(l);
    in_vld = 1'(vld);
  endtask

  initial begin
    int  nsingle;
    bit  seen;
    logic [6:0] idle_e;
    idle_e = E(3, 0, 0, 0, 0, 0);

    // LOAD, beat immediately
    add(1, 1, 0, 0, 0, 0, 0, idle_e);
    add(0, 0, 0, 0, 1, 0, 0, E(1, 0, 1, 0, 1, 0));
    add(0, 0, 0, 0, 0, 0, 0, E(3, 0, 0, 0, 1, 1));
    // LOAD with one wait cycle
    add(1, 1, 7, 0, 0, 0, 0, idle_e);
    add(0, 0, 0, 0, 0, 0, 0, E(3, 0, 1, 0, 1, 0));
    add(0, 0, 0, 0, 1, 0, 0, E(1, 0, 1, 0, 1, 0));
    add(0, 0, 0, 0, 0, 0, 0, E(3, 0, 0, 0, 1, 1));
    // MAC len 3, with an ignored start mid-command
    add(1, 0, 3, 0, 0, 0, 0, idle_e);
    add(0, 0, 0, 0, 1, 2, 3, E(0, 0, 1, 0, 1, 0));
    add(1, 2, 9, 0, 1, 1, 4, E(0, 0, 1, 0, 1, 0));
    add(0, 0, 0, 0, 1, 5, 1, E(0, 0, 1, 0, 1, 0));
    add(0, 0, 0, 0, 0, 0, 0, E(3, 0, 0, 1, 1, 1));
    add(0, 0, 0, 0, 0, 0, 0, idle_e);
    // zero-work commands
    add(1, 0, 0, 0, 1, 0, 0, idle_e);
    add(0, 0, 0, 0, 1, 0, 0, E(3, 0, 0, 0, 1, 1));
    add(1, 2, 0, 0, 1, 0, 0, idle_e);
    add(0, 0, 0, 0, 1, 0, 0, E(3, 0, 0, 0, 1, 1));
    add(1, 3, 5, 0, 1, 0, 0, idle_e);
    add(0, 0, 0, 0, 1, 0, 0, E(3, 0, 0, 0, 1, 1));
    // STREAM len 5 with gaps before beats 2 and 4
    add(1, 2, 5, 0, 0, 0, 0, idle_e);
    add(0, 0, 0, 0, 1, 0, 0, E(2, 1, 1, 0, 1, 0));
    add(0, 0, 0, 0, 0, 0, 0, E(3, 0, 1, 0, 1, 0));
    add(0, 0, 0, 0, 1, 0, 0, E(2, 1, 1, 0, 1, 0));
    add(0, 0, 0, 0, 1, 0, 0, E(2, 1, 1, 0, 1, 0));
    add(0, 0, 0, 0, 0, 0, 0, E(3, 0, 1, 0, 1, 0));
    add(0, 0, 0, 0, 1, 0, 0, E(2, 1, 1, 0, 1, 0));
    add(0, 0, 0, 0, 1, 0, 0, E(2, 1, 1, 1, 1, 0));
    add(0, 0, 0, 0, 1, 0, 0, E(2, 0, 0, 1, 1, 0));
    add(0, 0, 0, 0, 0, 0, 0, E(2, 0, 0, 1, 1, 0));
    add(0, 0, 0, 0, 0, 0, 0, E(2, 0, 0, 1, 1, 0));
    add(0, 0, 0, 0, 0, 0, 0, E(3, 0, 0, 1, 1, 1));
    add(0, 0, 0, 0, 0, 0, 0, idle_e);
    // abort + start in IDLE: abort wins
    add(1, 1, 0, 1, 1, 0, 0, idle_e);
    add(0, 0, 0, 0, 1, 0, 0, idle_e);
    // abort at STREAM beat 2 of 6, then STREAM len 1 sees a clean pipe
    add(1, 2, 6, 0, 0, 0, 0, idle_e);
    add(0, 0, 0, 0, 1, 0, 0, E(2, 1, 1, 0, 1, 0));
    add(0, 0, 0, 1, 1, 0, 0, E(3, 0, 0, 0, 1, 0));
    add(1, 2, 1, 0, 0, 0, 0, idle_e);
    add(0, 0, 0, 0, 1, 0, 0, E(2, 1, 1, 0, 1, 0));
    add(0, 0, 0, 0, 0, 0, 0, E(2, 0, 0, 0, 1, 0));
    add(0, 0, 0, 0, 0, 0, 0, E(2, 0, 0, 0, 1, 0));
    add(0, 0, 0, 0, 0, 0, 0, E(2, 0, 0, 0, 1, 0));
    add(0, 0, 0, 0, 0, 0, 0, E(3, 0, 0, 1, 1, 1));
    add(0, 0, 0, 0, 0, 0, 0, idle_e);

    rst = 1'b1;
    abort = 1'b0;
    op_a = '0;
    op_b = '0;
    drive(0, 0, 0, 0);
    @(negedge clk);
    #1 chk("reset", int'(got()), int'(idle_e));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < nv; i++) begin
      @(negedge clk);
      drive(int'(tv[i].st), int'(tv[i].cmd), int'(tv[i].len), int'(tv[i].vld));
      abort = tv[i].ab;
      op_a  = tv[i].a;
      op_b  = tv[i].b;
      #1 chk($sformatf("vec%0d", i), int'(got()), int'(tv[i].exp));
    end
    chk("mac_sum", acc, 15);

    // MAC at maximum length
    @(negedge clk);
    abort = 1'b0;
    op_a = '0;
    op_b = '0;
    drive(1, 0, 255, 1);
    nsingle = 0;
    seen = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      #1;
      if (mode_o == 2'd0) nsingle++;
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    chk("maxlen_beats", nsingle, 255);
    chk("maxlen_done", int'(seen), 1);
    in_vld = 1'b0;

    // ignored start in DRAIN, then async reset mid-DRAIN
    @(negedge clk);
    drive(1, 2, 1, 1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    drive(1, 1, 0, 0);
    #1 chk("drain_busy_start", int'(got()), int'(E(2, 0, 0, 0, 1, 0)));
    @(negedge clk);
    start = 1'b0;
    #1 chk("drain_still", int'(got()), int'(E(2, 0, 0, 0, 1, 0)));
    #2 rst = 1'b1;
    #1 chk("async_rst", int'(got()), int'(idle_e));
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst", int'(got()), int'(idle_e));
    @(negedge clk);
    drive(1, 1, 0, 1);
    @(negedge clk);
    start = 1'b0;
    #1 chk("post_rst_load", int'(got()), int'(E(1, 0, 1, 0, 1, 0)));
    @(negedge clk);
    in_vld = 1'b0;
    #1 chk("post_rst_fin", int'(got()), int'(E(3, 0, 0, 0, 1, 1)));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
